msg_receiver: RTL
=================

Name: msg_receiver

Overview:
- Receiving end of the header/argument message protocol. Consumes a stream of message_t words and reassembles each packet: one header, then N argument messages.
- Computes each packet's 32-bit result and queues (id, result) pairs in a small output FIFO drained through a valid/ready handshake.
- Checks the framing rules and reports violations on sticky error flags. Sits downstream of the message source, in place of a bare calculator.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16.
- SKIP_ID, 13'h1F83, id value the source never issues; expected-id sequence jumps over it.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- msg_valid  in  1  msg carries a word this cycle; no input backpressure
- msg  in  message_t  is_header, plus header {id[12:0], length[5:0], nothing[14:0]} or arg {op_t op, data[31:0]}
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  32  packet result
- res_id  out  13  packet id
- err_orphan  out  1  sticky: arg received while idle
- err_trunc  out  1  sticky: header arrived before previous packet completed
- err_first_op  out  1  sticky: first arg of a packet not SET
- err_overflow  out  1  sticky: result dropped, FIFO full
- err_id  out  1  sticky: header id not the expected id
- err_clr  in  1  clears all sticky errors

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset sets res_valid=0, res_data=0, res_id=0, all err_*=0, FIFO empty, FSM=IDLE, acc=0, remaining=0, id_seen=0.
- Words with msg_valid=0 are ignored; state holds.
- FSM IDLE:
  - Header with length=0: no result; stay IDLE.
  - Header with length N>0: latch id, remaining=N, first=1, go ARGS.
  - Arg: set err_orphan, discard.
- FSM ARGS, on each arg:
  - Operation on acc: SET acc=data; ADD acc+data; SUB acc-data; MUL low 32 bits of acc*data. All arithmetic is mod 2^32.
  - If first=1 and op!=SET: set err_first_op, execute as SET.
  - Clear first; decrement remaining.
  - When remaining reaches 0, push {id, final acc} into the FIFO at that clock edge, then go IDLE.
  - Latency: last arg in cycle t gives res_valid=1 in cycle t+1 when the FIFO was empty (first-word fall-through).
- FSM ARGS, on a header: set err_trunc, discard the partial packet with no push, then process the header exactly as in IDLE.
- FIFO:
  - A pop occurs when res_valid && res_ready.
  - Push when full without a same-cycle pop: drop the result, set err_overflow, FIFO unchanged.
  - Push when full with a same-cycle pop: both succeed.
  - Push and pop on an empty FIFO: the push is accepted; no pop, since res_valid=0.
  - res_data and res_id hold stable while res_valid=1 and res_ready=0.
- Sticky errors:
  - err_clr has priority over a same-cycle set; that event is lost.
  - Errors never stall or reset the FSM.
- Reset mid-packet: partial packet and FIFO contents are lost; no result is emitted.

Optional Feature:
- Macro: MSG_RECEIVER_ID_CHECK_EN.
- Defined:
  - Keep exp_id and id_seen.
  - The first header after reset is accepted unchecked and sets id_seen=1.
  - Each later header with id!=exp_id sets err_id.
  - After every header, exp_id = id+1, except id+1==SKIP_ID gives id+2. 13'h1FFF+1 wraps to 0.
  - exp_id resyncs from the received id even on a mismatch.
- Undefined: no exp_id or id_seen registers; err_id is tied 0.

Decomposition:
- Shared package msg_pkg: op_t, header_t, arg_t, message_t, constant SKIP_ID_DEFAULT=13'h1F83.
- Sub-module msg_rx_fifo: FIFO_DEPTH x 45-bit synchronous FIFO with first-word fall-through, full/empty flags and the simultaneous push/pop rule above.
- The FSM, accumulator and error logic stay in msg_receiver.

Test Plan:
- Basic packet: header(id=5,len=3), SET 10, ADD 7, MUL 3, res_ready=1. Expect res_valid one cycle after the MUL, res_id=5, res_data=51, no errors.
- Wrap and orphan: arg ADD 1 while IDLE sets err_orphan, with no result. Then header(len=2), SET 32'hFFFFFFFF, ADD 2 gives res_data=1. Pulsing err_clr clears err_orphan.
- Truncation: header(id=1,len=4), SET 1, ADD 1, then header(id=2,len=1), SET 9. Expect err_trunc, a single result (id=2, data=9), and no result for id 1.
- Backpressure: FIFO_DEPTH=4, res_ready=0, five 1-arg packets. Expect four results held stable and err_overflow=1 on the fifth. Raising res_ready drains ids in order.
- Id sequence (macro defined): headers 13'h1F81, 1F82, 1F84, 1F85 give no err_id. Then 1F87 sets err_id, and 1F88 following it gives no new error.
- First-op and reset: header(len=2), ADD 5, SUB 2 gives err_first_op and res_data=3. Asserting rst mid-packet gives empty FIFO, all flags 0 and FSM IDLE the next cycle.

Source files
------------

// File: rtl/msg_pkg.sv
// -----------------------------------------------------------------------------
// msg_pkg
// Shared types for the header/argument message protocol. A message word
// carries an is_header flag plus a 34-bit payload. The payload is either a
// header {id, length, nothing} or an argument {op, data}.
// Also holds the receiver FSM state type and the expected-id step function.
// -----------------------------------------------------------------------------
package msg_pkg;

    typedef enum logic [1:0] {
        OP_SET = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MUL = 2'd3
    } op_t;

    typedef struct packed {
        logic [12:0] id;
        logic [5:0]  length;
        logic [14:0] nothing;
    } header_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] data;
    } arg_t;

    localparam int PAYLOAD_W = 34;

    typedef struct packed {
        logic                 is_header;
        logic [PAYLOAD_W-1:0] payload;
    } message_t;

    localparam logic [12:0] SKIP_ID_DEFAULT = 13'h1F83;

    // Result FIFO entry: {id[12:0], result[31:0]}
    localparam int RES_W = 45;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ARGS = 1'b1
    } rx_state_t;

    // The source never issues skip_id. Its sequence therefore steps over that
    // value. The arithmetic is 13-bit, so 13'h1FFF is followed by 0.
    function automatic logic [12:0] next_exp_id(input logic [12:0] id,
                                                input logic [12:0] skip_id);
        logic [12:0] n;
        n = id + 13'd1;
        if (n == skip_id) n = id + 13'd2;
        return n;
    endfunction

endpackage

// File: rtl/msg_rx_fifo.sv
// -----------------------------------------------------------------------------
// msg_rx_fifo
// DEPTH x WIDTH synchronous FIFO with first-word fall-through. The head entry
// is visible on data_o whenever valid_o is high. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. Otherwise the push is
// ignored, and the parent flags the drop.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, data_i  write request and entry
//   pop_i           consumer takes the head (ignored while empty)
//   valid_o, data_o head valid and head entry (zero while empty)
//   full_o          no free slot
// -----------------------------------------------------------------------------
module msg_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty;
    logic             do_pop;
    logic             wr_en;

    assign empty  = (count_q == '0);
    assign full_o = (count_q == (AW+1)'(DEPTH));
    assign do_pop = pop_i && !empty;
    // When the FIFO is full, a same-cycle pop frees the slot that the push uses.
    assign wr_en  = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/msg_receiver.sv
// -----------------------------------------------------------------------------
// msg_receiver
// Reassembles header/argument packets, runs each packet's arithmetic on a
// 32-bit accumulator, and queues {id, result} in msg_rx_fifo. It reports
// framing violations on sticky error flags. err_clr clears all of the flags.
//
// Optional: define MSG_RECEIVER_ID_CHECK_EN to check the header id sequence.
// With it undefined, err_id is tied low.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   msg_valid, msg           input word stream (no backpressure)
//   res_valid/ready          result handshake; res_data, res_id are the head
//   err_orphan, err_trunc, err_first_op, err_overflow, err_id   sticky flags
//   err_clr                  clears every sticky flag (wins over a set)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a header; args here are orphans
// ST_ARGS | collecting args; remaining_q args still due
// -----------------------------------------------------------------------------
module msg_receiver
    import msg_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [12:0] SKIP_ID    = SKIP_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    input  message_t    msg,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [12:0] res_id,
    output logic        err_orphan,
    output logic        err_trunc,
    output logic        err_first_op,
    output logic        err_overflow,
    output logic        err_id,
    input  logic        err_clr
);

    rx_state_t   state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  remaining_q, remaining_d;
    logic        first_q, first_d;
    logic [12:0] pkt_id_q, pkt_id_d;
    // {orphan, trunc, first_op, overflow}
    logic [3:0]  err_q, err_set;

    header_t     hdr_w;
    arg_t        arg_w;
    op_t         eff_op;
    logic        hdr_evt, arg_evt, last_arg;
    logic        push_w, pop_w, fifo_full;
    logic [RES_W-1:0] fifo_head;
    logic        unused_hdr_nothing;

    assign hdr_w    = header_t'(msg.payload);
    assign arg_w    = arg_t'(msg.payload);
    assign hdr_evt  = msg_valid && msg.is_header;
    assign arg_evt  = msg_valid && !msg.is_header;
    assign last_arg = arg_evt && (state_q == ST_ARGS) && (remaining_q == 6'd1);
    assign unused_hdr_nothing = ^hdr_w.nothing;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_evt && hdr_w.length != 6'd0) state_d = ST_ARGS;
            end
            ST_ARGS: begin
                // A header here abandons the partial packet and then starts over as from IDLE.
                if (hdr_evt)       state_d = (hdr_w.length != 6'd0) ? ST_ARGS : ST_IDLE;
                else if (last_arg) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        push_w  = 1'b0;
        err_set = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                err_set[3] = arg_evt;
            end
            ST_ARGS: begin
                err_set[2] = hdr_evt;
                err_set[1] = arg_evt && first_q && (arg_w.op != OP_SET);
                push_w     = last_arg;
            end
            default: ;
        endcase
        err_set[0] = push_w && fifo_full && !pop_w;
    end

    // ---------------- packet datapath ----------------
    always_comb begin
        acc_d       = acc_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        pkt_id_d    = pkt_id_q;
        // A packet that does not open with SET still gets a defined start value.
        eff_op      = (first_q && arg_w.op != OP_SET) ? OP_SET : arg_w.op;
        if (hdr_evt) begin
            if (hdr_w.length != 6'd0) begin
                pkt_id_d    = hdr_w.id;
                remaining_d = hdr_w.length;
                first_d     = 1'b1;
            end
        end else if (arg_evt && state_q == ST_ARGS) begin
            case (eff_op)
                OP_SET:  acc_d = arg_w.data;
                OP_ADD:  acc_d = acc_q + arg_w.data;
                OP_SUB:  acc_d = acc_q - arg_w.data;
                OP_MUL:  acc_d = acc_q * arg_w.data;
                default: acc_d = acc_q;
            endcase
            first_d     = 1'b0;
            remaining_d = remaining_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            pkt_id_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            pkt_id_q    <= pkt_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          err_q <= '0;
        else if (err_clr) err_q <= '0;
        else              err_q <= err_q | err_set;
    end

    assign err_orphan   = err_q[3];
    assign err_trunc    = err_q[2];
    assign err_first_op = err_q[1];
    assign err_overflow = err_q[0];

`ifdef MSG_RECEIVER_ID_CHECK_EN
    logic [12:0] exp_id_q, exp_id_d;
    logic        id_seen_q, id_seen_d;
    logic        err_id_q, id_mismatch;

    // The expected id follows the received id, even after a mismatch.
    always_comb begin
        exp_id_d    = exp_id_q;
        id_seen_d   = id_seen_q;
        id_mismatch = 1'b0;
        if (hdr_evt) begin
            id_mismatch = id_seen_q && (hdr_w.id != exp_id_q);
            exp_id_d    = next_exp_id(hdr_w.id, SKIP_ID);
            id_seen_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_id_q  <= '0;
            id_seen_q <= 1'b0;
            err_id_q  <= 1'b0;
        end else begin
            exp_id_q  <= exp_id_d;
            id_seen_q <= id_seen_d;
            if (err_clr) err_id_q <= 1'b0;
            else         err_id_q <= err_id_q | id_mismatch;
        end
    end

    assign err_id = err_id_q;
`else
    logic unused_skip_id;
    assign unused_skip_id = ^SKIP_ID;
    assign err_id = 1'b0;
`endif

    // ---------------- result FIFO ----------------
    assign pop_w = res_valid && res_ready;

    msg_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_w),
        .data_i  ({pkt_id_q, acc_d}),
        .pop_i   (pop_w),
        .valid_o (res_valid),
        .data_o  (fifo_head),
        .full_o  (fifo_full)
    );

    assign res_id   = fifo_head[44:32];
    assign res_data = fifo_head[31:0];

endmodule
